branch_predictor: RTL
=====================

# branch_predictor

Parametrised branch target buffer with 2-bit saturating direction counters for the pipelined MIPS core. It sits beside the fetch stage: fetch looks up the PC combinationally and receives a predicted next PC. The execute stage reports each resolved branch/jump so the table can be trained. It also keeps saturating branch and mispredict counters for performance analysis.

## Interface

Parameters:
- ENTRIES, 16, number of table entries; power of two, ≥2; IDX_W = log2(ENTRIES)
- CNT_W, 16, width of statistics counters
- CTR_RST, 2'b01, counter value loaded at reset and on flush (weakly not-taken)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- fetch_pc  in  32  PC presented by fetch (word aligned)
- pred_taken  out  1  table hit and counter MSB = 1
- pred_target  out  32  predicted next PC
- pred_hit  out  1  valid entry with matching tag for fetch_pc
- upd_valid  in  1  execute reports a resolved control-flow instruction this cycle
- upd_pc  in  32  PC of the resolved instruction
- upd_taken  in  1  actual outcome
- upd_target  in  32  actual taken target
- upd_mispredict  in  1  execute detected a wrong prediction (qualified by upd_valid)
- flush  in  1  synchronous table invalidate
- branch_cnt  out  CNT_W  resolved-branch count
- mispred_cnt  out  CNT_W  mispredict count

## Operation

- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. Per entry: valid, tag, target[31:0], ctr[1:0].
- Lookup (combinational, no state change): pred_hit = valid[idx] && tag match.
  - pred_taken = pred_hit && ctr[1].
  - pred_target = pred_taken ? target[idx] : fetch_pc + 4 (32-bit wrap: 0xFFFFFFFC -> 0x00000000).
- Update, when upd_valid = 1 at the clock edge:
  - Hit on upd_pc: ctr increments if upd_taken (saturates at 2'b11), else decrements (saturates at 2'b00). Target is overwritten with upd_target only when upd_taken.
  - Miss and upd_taken: allocate (overwrite whatever is at the index): valid = 1, tag, target = upd_target, ctr = 2'b10.
  - Miss and not taken: no table change.
  - branch_cnt += 1. mispred_cnt += 1 if upd_mispredict. Both saturate at all-ones and do not wrap.
- Flush: clears every valid bit and sets every ctr to CTR_RST. Tags and targets are don't-care. Statistics counters are unaffected.
- Flush and upd_valid in the same cycle: flush wins and the table update is dropped; statistics still count.
- upd_mispredict with upd_valid = 0 is ignored.

## Timing

- Lookup has zero latency (combinational from fetch_pc and current table state).
- Update is visible to lookup in the cycle after the edge that wrote it. There is no same-cycle bypass: a lookup at the index being updated returns the old contents.
- Reset (asynchronous, immediate): all valid = 0, all ctr = CTR_RST, branch_cnt = 0, mispred_cnt = 0. Outputs settle to pred_hit = 0, pred_taken = 0, pred_target = fetch_pc + 4. RST asserted mid-update aborts the update; no partial entry survives.
- One update per cycle, with no backpressure. The caller holds upd_valid high for exactly one cycle per resolved instruction, and fetch stalls do not gate updates.
- Flush takes effect at the edge and costs one cycle; lookups in the following cycle miss.

## Test plan

- Reset, then fetch_pc = 0x00000040: pred_hit = 0, pred_taken = 0, pred_target = 0x00000044, both counters 0.
- Update pc = 0x40, taken, target 0x100, then lookup 0x40: hit, ctr = 10, pred_taken = 1, pred_target = 0x100, branch_cnt = 1. Lookup in the same cycle as the update still misses.
- Four more taken updates on 0x40, then three not-taken updates: ctr path 11 (saturated) -> 10 -> 01 -> 00. Lookup gives pred_taken = 0 with pred_hit = 1. A fourth not-taken update leaves ctr at 00.
- Alias test (ENTRIES = 16): allocate 0x40, then taken update at 0x80 (same index, different tag). Lookup 0x40 misses and lookup 0x80 hits with the new target. A not-taken update on a missing PC leaves the table unchanged.
- Flush with simultaneous upd_valid on a new PC: all lookups miss next cycle, no allocation occurs, branch_cnt still increments. Assert RST mid-sequence: outputs return to reset values asynchronously, before the next edge.
- Counter saturation with CNT_W = 4: 20 updates, all with upd_mispredict = 1. branch_cnt = mispred_cnt = 15. fetch_pc = 0xFFFFFFFC on a miss gives pred_target = 0x00000000.

Source files
------------

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup, execute training and statistics signals
// for the branch target buffer.
//   master : fetch/execute side (drives fetch_pc, upd_*, flush)
//   slave  : predictor side (drives pred_*, branch_cnt, mispred_cnt)
interface branch_predictor_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      fetch_pc;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             pred_hit;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic             upd_mispredict;
  logic             flush;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush,
    input  pred_taken, pred_target, pred_hit, branch_cnt, mispred_cnt
  );

  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush,
    output pred_taken, pred_target, pred_hit, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with 2-bit saturating
// direction counters, plus saturating resolved-branch / mispredict counters.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bp       : branch_predictor_if.slave
//              - lookup:  fetch_pc -> pred_hit / pred_taken / pred_target (combinational)
//              - train:   upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict
//              - flush:   synchronous invalidate of the whole table
//              - stats:   branch_cnt, mispred_cnt
// The bp interface must be instantiated with the same CNT_W as this module.
module branch_predictor #(
  parameter int         ENTRIES = 16,
  parameter int         CNT_W   = 16,
  parameter logic [1:0] CTR_RST = 2'b01
) (
  input  logic                clk,
  input  logic                rst,
  branch_predictor_if.slave   bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0]            valid_q;
  logic [ENTRIES-1:0][1:0]       ctr_q;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
  logic [ENTRIES-1:0][31:0]      tgt_q;
  logic [CNT_W-1:0]              bcnt_q, mcnt_q;

  // Byte-offset bits carry no information for word-aligned PCs.
  logic unused;
  assign unused = ^{bp.fetch_pc[1:0], bp.upd_pc[1:0]};

  // ---------------- lookup ----------------
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  assign f_idx = bp.fetch_pc[IDX_W+1:2];
  assign f_tag = bp.fetch_pc[31:IDX_W+2];

  assign bp.pred_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign bp.pred_taken  = bp.pred_hit && ctr_q[f_idx][1];
  assign bp.pred_target = bp.pred_taken ? tgt_q[f_idx] : bp.fetch_pc + 32'd4;

  // ---------------- update ----------------
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             tbl_we;
  assign u_idx  = bp.upd_pc[IDX_W+1:2];
  assign u_tag  = bp.upd_pc[31:IDX_W+2];
  assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign tbl_we = bp.upd_valid && !bp.flush;

  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? c : c + 2'b01;
    else   return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      ctr_q   <= {ENTRIES{CTR_RST}};
    end else if (bp.flush) begin
      valid_q <= '0;
      ctr_q   <= {ENTRIES{CTR_RST}};
    end else if (tbl_we) begin
      if (u_hit) begin
        ctr_q[u_idx] <= ctr_step(ctr_q[u_idx], bp.upd_taken);
      end else if (bp.upd_taken) begin
        valid_q[u_idx] <= 1'b1;
        ctr_q[u_idx]   <= 2'b10;
      end
    end
  end

  // Tag/target need no reset: they are only observed behind valid_q.
  // A taken update writes both on hit (tag unchanged) and on allocation.
  always_ff @(posedge clk) begin
    if (tbl_we && bp.upd_taken) begin
      tag_q[u_idx] <= u_tag;
      tgt_q[u_idx] <= bp.upd_target;
    end
  end

  // ---------------- statistics ----------------
  // Flush does not suppress counting; both counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else if (bp.upd_valid) begin
      if (bcnt_q != '1) bcnt_q <= bcnt_q + 1'b1;
      if (bp.upd_mispredict && mcnt_q != '1) mcnt_q <= mcnt_q + 1'b1;
    end
  end

  assign bp.branch_cnt  = bcnt_q;
  assign bp.mispred_cnt = mcnt_q;
endmodule
